// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animation layer.
package sprite_pkg;

  typedef enum logic [1:0] {
    M_ONESHOT  = 2'd0,
    M_LOOP     = 2'd1,
    M_PINGPONG = 2'd2,
    M_RSVD     = 2'd3
  } anim_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } anim_state_t;

  localparam logic [3:0] ST_ACTIVE = 4'd5;

endpackage

// File: rtl/anim_sequencer.sv
// Frame sequencer: hold counter, frame index and ping-pong direction,
// advanced once per video frame while the game is active.
module anim_sequencer
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 3,
  parameter int FRAME_HOLD = 120,
  parameter int FI_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic [1:0]      mode,
  input  logic            pause,
  output logic            showing,
  output logic [FI_W-1:0] frame_idx,
  output logic            done
);

  localparam int HC_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(FRAME_HOLD - 1);
  localparam logic [FI_W-1:0] FRAME_LAST = FI_W'(NUM_FRAMES - 1);

  anim_state_t     state;
  anim_mode_t      mode_q;
  logic [HC_W-1:0] hold_cnt;
  logic            dir_up;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= M_LOOP;
      frame_idx <= '0;
      hold_cnt  <= '0;
      dir_up    <= 1'b1;
      done      <= 1'b0;
      showing   <= 1'b0;
    end else if (!active) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      showing <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_PLAY;
          showing   <= 1'b1;
          mode_q    <= anim_mode_t'(mode);
          frame_idx <= '0;
          hold_cnt  <= '0;
          dir_up    <= 1'b1;
        end
        S_PLAY: begin
          if (!pause) begin
            if (hold_cnt != HOLD_LAST) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt <= '0;
              case (mode_q)
                M_ONESHOT: begin
                  if (frame_idx == FRAME_LAST) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                  end else begin
                    frame_idx <= frame_idx + 1'b1;
                  end
                end
                M_PINGPONG: begin
                  // Turn around at either end so the end frame is shown once per sweep.
                  if (NUM_FRAMES > 1) begin
                    if (dir_up) begin
                      if (frame_idx == FRAME_LAST) begin
                        frame_idx <= frame_idx - 1'b1;
                        dir_up    <= 1'b0;
                      end else begin
                        frame_idx <= frame_idx + 1'b1;
                      end
                    end else begin
                      if (frame_idx == '0) begin
                        frame_idx <= frame_idx + 1'b1;
                        dir_up    <= 1'b1;
                      end else begin
                        frame_idx <= frame_idx - 1'b1;
                      end
                    end
                  end
                end
                default: begin
                  frame_idx <= (frame_idx == FRAME_LAST) ? '0 : frame_idx + 1'b1;
                end
              endcase
            end
          end
        end
        S_DONE: ;
        default: begin
          state   <= S_IDLE;
          showing <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// Multi-frame sprite sequencer plus box test and sprite ROM address
// generation for the VGA sprite layer.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int         NUM_FRAMES    = 3,
  parameter int         FRAME_HOLD    = 120,
  parameter int         X0            = 279,
  parameter int         Y0            = 124,
  parameter int         SPR_W         = 82,
  parameter int         SPR_H         = 86,
  parameter logic [3:0] ACTIVE_STATUS = ST_ACTIVE,
  parameter int         ADDR_W        = 20,
  localparam int        FI_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic [3:0]        status,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              is_sprite,
  output logic [FI_W-1:0]   frame_idx,
  output logic [ADDR_W-1:0] sprite_address,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);

  logic              active;
  logic              showing;
  logic              box;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;

  assign active = (status == ACTIVE_STATUS);

  anim_sequencer #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FI_W       (FI_W)
  ) u_seq (
    .clk       (frame_clk),
    .rst_n     (Reset_n),
    .active    (active),
    .mode      (mode),
    .pause     (pause),
    .showing   (showing),
    .frame_idx (frame_idx),
    .done      (done)
  );

  assign box = (int'(DrawX) >= X0) && (int'(DrawX) < X0 + SPR_W) &&
               (int'(DrawY) >= Y0) && (int'(DrawY) < Y0 + SPR_H);

  // Offsets only meaningful inside the box; the result is masked outside it.
  assign dx = ADDR_W'(DrawX) - ADDR_W'(X0);
  assign dy = ADDR_W'(DrawY) - ADDR_W'(Y0);

  assign is_sprite      = box && showing && active;
  assign sprite_address = (box && showing) ? ADDR_W'(frame_idx) * FRAME_SZ + dx + dy * ROW_SZ
                                           : '0;

endmodule
